lcd_write_sched: RTL

Scheduler sitting between the CPU-facing LCD register block and the LCD parallel write engine. It latches "run init sequence" and "fill N pixels" requests, arbitrates between them with init priority, and starts the engine in the matching mode. It counts completed words from the engine's per-word address strobe, supplies the word index to the init ROM / pixel source, and asserts stop on the last word. It reports busy/done/abort to software.

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_word_cnt.sv | 47 ++++
 rtl/lcd_write_sched.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write scheduler: FSM encoding, engine mode
// selection and default panel dimensions.
package lcd_pkg;

    localparam int CNT_W_DEF    = 17;
    localparam int PANEL_PIXELS = 76800;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_RUN   = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    typedef enum logic {
        MODE_INI   = 1'b0,
        MODE_COLOR = 1'b1
    } mode_e;

endpackage

// File: rtl/lcd_word_cnt.sv
// Word counter for one engine run: remaining words count down while the
// word index counts up; last flags report when nothing remains after this word.
module lcd_word_cnt
    import lcd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] addr_o,
    output logic             last_o,
    output logic             last_next_o
);

    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] addr_q, addr_d;

    always_comb begin
        remain_d = remain_q;
        addr_d   = addr_q;
        if (load_i) begin
            remain_d = load_val_i;
            addr_d   = '0;
        end else if (step_i && (remain_q != '0)) begin
            remain_d = remain_q - CNT_W'(1);
            addr_d   = addr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            remain_q <= '0;
            addr_q   <= '0;
        end else begin
            remain_q <= remain_d;
            addr_q   <= addr_d;
        end
    end

    assign addr_o      = addr_q;
    assign last_o      = (remain_q == '0);
    assign last_next_o = (remain_d == '0);

endmodule

// File: rtl/lcd_write_sched.sv
// Schedules init-sequence and colour-fill runs onto the LCD write engine,
// counting words from the engine strobe and reporting busy/done/abort.
module lcd_write_sched
    import lcd_pkg::*;
#(
    parameter int INI_LEN = 64,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ini_req_i,
    input  logic             fill_req_i,
    input  logic [CNT_W-1:0] fill_len_i,
    input  logic             abort_i,
    input  logic             eng_addr_en_i,
    output logic             eng_trans_o,
    output logic             eng_stop_o,
    output logic             eng_ini_en_o,
    output logic             eng_color_en_o,
    output logic [CNT_W-1:0] word_addr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    localparam logic [CNT_W-1:0] INI_LAST = CNT_W'(INI_LEN - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             ini_pend_q, ini_pend_d;
    logic             fill_pend_q, fill_pend_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic             ini_eff, fill_eff, running;
    logic [CNT_W-1:0] take_len;
    logic             cnt_load, cnt_step, cnt_last, cnt_last_next;
    logic [CNT_W-1:0] cnt_load_val;
    logic             zero_done, abort_hit, run_d;

    logic trans_q, trans_d, stop_q, stop_d;
    logic ini_en_q, ini_en_d, color_en_q, color_en_d;
    logic busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

    // A request arriving this cycle is usable immediately; an older pending
    // fill keeps its own length even if a new one overwrites len_q.
    assign ini_eff  = ini_pend_q | ini_req_i;
    assign fill_eff = fill_pend_q | fill_req_i;
    assign take_len = fill_pend_q ? len_q : fill_len_i;
    assign running  = (state_q == ST_START) || (state_q == ST_RUN);

    lcd_word_cnt #(
        .CNT_W (CNT_W)
    ) u_word_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (cnt_load),
        .load_val_i  (cnt_load_val),
        .step_i      (cnt_step),
        .addr_o      (word_addr_o),
        .last_o      (cnt_last),
        .last_next_o (cnt_last_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_INI;
            ini_pend_q  <= 1'b0;
            fill_pend_q <= 1'b0;
            len_q       <= '0;
            trans_q     <= 1'b0;
            stop_q      <= 1'b0;
            ini_en_q    <= 1'b0;
            color_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ini_pend_q  <= ini_pend_d;
            fill_pend_q <= fill_pend_d;
            len_q       <= len_d;
            trans_q     <= trans_d;
            stop_q      <= stop_d;
            ini_en_q    <= ini_en_d;
            color_en_q  <= color_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ini_pend_d   = ini_eff;
        fill_pend_d  = fill_eff;
        len_d        = fill_req_i ? fill_len_i : len_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_step     = 1'b0;
        zero_done    = 1'b0;
        abort_hit    = 1'b0;

        if (abort_i) begin
            ini_pend_d  = 1'b0;
            fill_pend_d = 1'b0;
            abort_hit   = running | ini_eff | fill_eff;
            if (running) begin
                state_d = ST_IDLE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Taking a flag consumes the older request; a same-cycle new one stays pending.
                if (!abort_i) begin
                    if (ini_eff) begin
                        mode_d       = MODE_INI;
                        cnt_load     = 1'b1;
                        cnt_load_val = INI_LAST;
                        ini_pend_d   = ini_pend_q & ini_req_i;
                        state_d      = ST_START;
                    end else if (fill_eff) begin
                        fill_pend_d = fill_pend_q & fill_req_i;
                        if (take_len != '0) begin
                            mode_d       = MODE_COLOR;
                            cnt_load     = 1'b1;
                            cnt_load_val = take_len - CNT_W'(1);
                            state_d      = ST_START;
                        end else begin
                            zero_done = 1'b1;
                        end
                    end
                end
            end
            ST_START, ST_RUN: begin
                if (!abort_i) begin
                    state_d = ST_RUN;
                    if (eng_addr_en_i) begin
                        if (cnt_last) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_step = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run_d      = (state_d == ST_START) || (state_d == ST_RUN);
        trans_d    = run_d;
        stop_d     = run_d && cnt_last_next;
        ini_en_d   = run_d && (mode_d == MODE_INI);
        color_en_d = run_d && (mode_d == MODE_COLOR);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE) || zero_done;
        aborted_d  = abort_hit;
    end

    assign eng_trans_o    = trans_q;
    assign eng_stop_o     = stop_q;
    assign eng_ini_en_o   = ini_en_q;
    assign eng_color_en_o = color_en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;

endmodule
